// File: rtl/prog_tick_gen_if.sv
// Register-access and tick-output bundle for prog_tick_gen.
//   wen/waddr/wdata : single-cycle register write. waddr[4:1] = channel,
//                     waddr[0] = select (0 = DIV, 1 = CTRL)
//   ren/raddr/rdata : register read. rdata is registered and valid the
//                     cycle after ren
//   tick            : per-channel one-cycle pulse at each period wrap
//   toggle          : per-channel square wave that flips at each wrap
// master = register host side, slave = prog_tick_gen side.
interface prog_tick_gen_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  logic                wen;
  logic [4:0]          waddr;
  logic [WIDTH-1:0]    wdata;
  logic                ren;
  logic [4:0]          raddr;
  logic [WIDTH-1:0]    rdata;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] toggle;

  modport master (
    output wen, waddr, wdata, ren, raddr,
    input  rdata, tick, toggle
  );

  modport slave (
    input  wen, waddr, wdata, ren, raddr,
    output rdata, tick, toggle
  );
endinterface

// File: rtl/prog_tick_gen.sv
// Programmable multi-channel tick / square-wave generator.
// Each channel counts 0..div and wraps; a wrap produces a one-cycle tick
// (registered, so it appears the cycle after the wrap) and flips toggle.
// Tick period = div+1 cycles, toggle period = 2*(div+1) cycles.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : prog_tick_gen_if.slave (register access + tick/toggle outputs)
// Registers per channel (waddr/raddr = {channel[3:0], select}):
//   DIV  (select 0) : shadow divider; moved into the active divider at the
//                     next wrap (or immediately if written on a wrap cycle)
//   CTRL (select 1) : write bit0 = enable, bit1 = restart (self-clearing);
//                     read  {0, running, enable} with running = enable
// Channels at index >= CHANNELS ignore writes and read back as 0.
module prog_tick_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 0,
  parameter bit          DEFAULT_EN  = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  prog_tick_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  // Full 16-entry views of per-channel state so the read mux can index any
  // address; unimplemented channels are tied to zero.
  logic [WIDTH-1:0]    shd_v [16];
  logic [15:0]         en_v;
  logic [CHANNELS-1:0] tick_v;
  logic [CHANNELS-1:0] tog_v;
  logic [WIDTH-1:0]    rdata_q;

  for (genvar g = 0; g < 16; g++) begin : g_ch
    if (g < CHANNELS) begin : g_live
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] act;
      logic [WIDTH-1:0] shd;
      logic             en;
      logic             tick_q;
      logic             tog_q;
      logic             div_wr;
      logic             ctl_wr;
      logic             restart;

      assign div_wr  = bus.wen && (bus.waddr[4:1] == 4'(g)) && !bus.waddr[0];
      assign ctl_wr  = bus.wen && (bus.waddr[4:1] == 4'(g)) &&  bus.waddr[0];
      assign restart = ctl_wr && bus.wdata[1];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt    <= '0;
          act    <= DIV_RST;
          shd    <= DIV_RST;
          en     <= DEFAULT_EN;
          tick_q <= 1'b0;
          tog_q  <= 1'b0;
        end else begin
          if (div_wr) shd <= bus.wdata;
          if (ctl_wr) en  <= bus.wdata[0];

          if (restart) begin
            cnt    <= '0;
            tog_q  <= 1'b0;
            tick_q <= 1'b0;
            act    <= shd;
          end else if (en) begin
            if (cnt == act) begin
              cnt    <= '0;
              tick_q <= 1'b1;
              tog_q  <= ~tog_q;
              // A DIV write landing on the wrap cycle bypasses the shadow
              // so it governs the period that starts now.
              act    <= div_wr ? bus.wdata : shd;
            end else begin
              cnt    <= cnt + WIDTH'(1);
              tick_q <= 1'b0;
            end
          end else begin
            tick_q <= 1'b0;
          end
        end
      end

      assign shd_v[g]  = shd;
      assign en_v[g]   = en;
      assign tick_v[g] = tick_q;
      assign tog_v[g]  = tog_q;
    end else begin : g_none
      assign shd_v[g] = '0;
      assign en_v[g]  = 1'b0;
    end
  end

  // Registered read; samples pre-write state so a same-cycle write to the
  // register being read returns the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (bus.ren) begin
      if (bus.raddr[0])
        rdata_q <= {{(WIDTH-2){1'b0}}, en_v[bus.raddr[4:1]], en_v[bus.raddr[4:1]]};
      else
        rdata_q <= shd_v[bus.raddr[4:1]];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.tick   = tick_v;
  assign bus.toggle = tog_v;

endmodule

// File: doc/prog_tick_gen.md
PROG_TICK_GEN -- requirements
Module: prog_tick_gen

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 4, as the number of independent divider channels (1..16).
REQ-002 The block SHALL take parameter WIDTH, default 16, as the divider/counter width in bits (2..32).
REQ-003 The block SHALL take parameter DEFAULT_DIV, default 0, as the reset value of every channel's divider.
REQ-004 The block SHALL take parameter DEFAULT_EN, default 1, as the reset value of every channel's enable.
REQ-005 clock  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wen  in  1  write strobe, single-cycle.
REQ-008 waddr  in  5  write address: [4:1] channel, [0] select (0=DIV, 1=CTRL).
REQ-009 wdata  in  WIDTH  write data.
REQ-010 ren  in  1  read strobe.
REQ-011 raddr  in  5  read address, same encoding as waddr.
REQ-012 rdata  out  WIDTH  read data, registered.
REQ-013 tick  out  CHANNELS  per-channel one-cycle pulse at each period wrap.
REQ-014 toggle  out  CHANNELS  per-channel square wave, flips at each wrap.

Function
REQ-015 Each channel SHALL hold: active divider, shadow divider, enable, counter (all WIDTH or 1 bit).
REQ-016 An enabled channel SHALL increment its counter each cycle; when counter == active divider it SHALL reset to 0, assert tick the following cycle for exactly one cycle, and flip toggle.
REQ-017 Tick period SHALL be div+1 cycles; toggle period 2*(div+1) cycles, i.e. div = (f_clock/f_out)/2-1 yields f_out on toggle.
REQ-018 div = 0 SHALL give tick high continuously and toggle flipping every cycle.
REQ-019 A DIV write SHALL update the shadow divider only; active divider SHALL load from shadow at the next wrap.
REQ-020 A DIV write coinciding with a wrap SHALL be forwarded: the written value governs the very next period.
REQ-021 CTRL write: wdata[0] SHALL set enable; wdata[1]=1 SHALL restart (counter 0, toggle 0, active := shadow or forwarded wdata, tick 0) in the following cycle; restart bit is not stored.
REQ-022 A disabled channel SHALL hold counter and toggle, drive tick 0, and still accept DIV writes.
REQ-023 Re-enable SHALL resume counting from the held counter value.
REQ-024 Read: rdata SHALL present, the cycle after ren, the shadow divider (select 0) or {0, running, enable} (select 1) where running = enable.
REQ-025 rdata SHALL hold its last value when ren is low.
REQ-026 Accesses to channel index >= CHANNELS SHALL be ignored for writes and return 0 for reads.
REQ-027 Simultaneous ren and wen to the same register SHALL return the pre-write value.
REQ-028 Channels SHALL be fully independent; no cross-channel coupling.

Reset
REQ-029 On reset assertion, independent of clock: counters 0, tick 0, toggle 0, active and shadow dividers DEFAULT_DIV, enable DEFAULT_EN, rdata 0.
REQ-030 Reset mid-period SHALL discard pending shadow values; first tick after release SHALL occur DEFAULT_DIV+1 cycles after the first enabled edge.

Verification
REQ-031 Reset release, DEFAULT_DIV=0, DEFAULT_EN=1 -> all ticks high continuously, toggles flip every cycle.
REQ-032 Write DIV=3 to ch1, CTRL=3 to ch1 -> ch1 tick every 4 cycles, toggle period 8; ch0 unaffected.
REQ-033 ch2 running DIV=9; write DIV=1 at counter=4 -> remaining period completes at 10 cycles, then ticks every 2 cycles; DIV write on wrap cycle -> new value applies immediately.
REQ-034 CTRL=0 on ch3 at counter=5 -> tick 0, toggle frozen; CTRL=1 later -> next tick after remaining (div-5) cycles.
REQ-035 Read ch1 DIV after write 0x00AB -> rdata 0x00AB next cycle; read channel 15 with CHANNELS=4 -> 0; write to channel 15 -> no state change.
REQ-036 Assert reset mid-period with pending shadow -> outputs 0 immediately, dividers back to DEFAULT_DIV after release.
